lock_cycle_controller: RTL
==========================

Name: lock_cycle_controller

Overview:
- Canal-lock sequencing FSM that sits directly downstream of the arrival/departure signal stage.
- Consumes the synchronized arrive/depart request levels and drives outer/inner gate-open and pressure-up/pressure-down (fill/drain) commands through a full lockage.
- All durations are timed in whole seconds from a shared 1 Hz tick.
- Convention: outer side = low water (bay); inner side = high water (lake).

Parameters:
- FILL_SECS, 7: ticks pressure_up stays asserted per fill; must be >= 1.
- DRAIN_SECS, 7: ticks pressure_down stays asserted per drain; must be >= 1.
- GATE_SECS, 5: ticks a gate stays open for boat entry or exit; must be >= 1.
- CNT_W, 10: timer / secs_left width; every *_SECS value must be < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-clk-wide enable pulse, once per second.
- arrive_signal  in  1  synchronized arrival request level (boat at bay side, going up).
- depart_signal  in  1  synchronized departure request level (boat at lake side, going down).
- outer_gate_open  out  1  open command, outer gate.
- inner_gate_open  out  1  open command, inner gate.
- pressure_up  out  1  fill valve command.
- pressure_down  out  1  drain valve command.
- chamber_high  out  1  chamber water level flag: 1 = lake level, 0 = bay level.
- busy  out  1  high in every state except IDLE.
- secs_left  out  CNT_W  remaining ticks in the current timed state; 0 in IDLE.
- done  out  1  one-clk pulse on return to IDLE after a lockage.

Behaviour:
- Reset (rst=0, async): state=IDLE, chamber_high=0, every command output 0, secs_left=0, done=0, both pending flags and both edge-detect registers cleared.
- Requests are rising edges of arrive_signal / depart_signal, detected with a 1-clk registered previous value. An edge sets pending_arr / pending_dep. Held levels do not retrigger.
- States: IDLE, PREP_DRAIN, PREP_FILL, ENTER_OUTER, ENTER_INNER, RAISE, LOWER, EXIT_INNER, EXIT_OUTER.
- Output decode is registered and one-hot:
  - outer_gate_open: ENTER_OUTER, EXIT_OUTER.
  - inner_gate_open: ENTER_INNER, EXIT_INNER.
  - pressure_up: PREP_FILL, RAISE.
  - pressure_down: PREP_DRAIN, LOWER.
- IDLE dispatch, evaluated each clk:
  - pending_arr has priority over pending_dep.
  - Arrival: go to ENTER_OUTER if chamber_high=0, else PREP_DRAIN.
  - Departure: go to ENTER_INNER if chamber_high=1, else PREP_FILL.
  - The dispatched pending flag clears on the same edge.
- Arrival path: [PREP_DRAIN] -> ENTER_OUTER -> RAISE -> EXIT_INNER -> IDLE.
- Departure path: [PREP_FILL] -> ENTER_INNER -> LOWER -> EXIT_OUTER -> IDLE.
- Timer:
  - On entry to a timed state, the timer loads that state's *_SECS value.
  - It decrements on tick_1hz.
  - When the timer is 1 and a tick arrives, the FSM advances on that edge.
  - A tick on the entry edge itself is not counted.
  - secs_left mirrors the timer.
- chamber_high updates:
  - Set to 1 on exit from RAISE or PREP_FILL.
  - Cleared to 0 on exit from LOWER or PREP_DRAIN.
- done pulses on the clk the FSM enters IDLE from EXIT_INNER or EXIT_OUTER.
- Requests arriving while busy are latched, not dropped. One of each kind is held; duplicates merge.
- Both requests pending at IDLE: arrival is served first, then departure on the next IDLE cycle.
- Safety invariants (must hold every cycle):
  - The two gates are never open together.
  - pressure_up and pressure_down are never both high.
  - No gate is open while either pressure output is high.
  - outer_gate_open implies chamber_high=0; inner_gate_open implies chamber_high=1.
- Reset mid-lockage: immediate return to reset values; pending requests are lost.

Decomposition:
- Shared package lock_pkg: state encoding constants (4-bit), default *_SECS constants, CNT_W.
- One sub-module, lock_timer: loadable down-counter with tick enable and expire flag.
- The FSM, edge detect, and pending latches stay in lock_cycle_controller.

Test Plan:
Bench parameters: FILL=3, DRAIN=3, GATE=2; tick every 4 clk.
- Reset then arrive edge -> outer_gate_open for 2 ticks, pressure_up 3 ticks, inner_gate_open 2 ticks, done pulse; chamber_high=1 at end; busy low after.
- From chamber_high=1, arrive edge -> PREP_DRAIN, pressure_down 3 ticks, then normal arrival sequence; chamber_high ends 1.
- arrive and depart edges on the same clk with chamber_high=0 -> arrival runs first; then, with no further input, the departure runs: inner 2, down 3, outer 2; chamber_high ends 0; two done pulses.
- depart edge during RAISE, plus a second depart edge -> a single departure served after done; no extra lockage.
- arrive_signal held high for 50 clk -> exactly one lockage.
- rst asserted mid-RAISE (secs_left=2) -> all outputs 0 asynchronously, chamber_high=0, IDLE.
- All scenarios: invariant assertions on gates, pressure outputs, and chamber level never fire.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the canal-lock controller: state encoding,
// default durations (in 1 Hz ticks) and the default timer width.
package lock_pkg;

  localparam int LOCK_CNT_W       = 10;
  localparam int DEF_FILL_SECS    = 7;
  localparam int DEF_DRAIN_SECS   = 7;
  localparam int DEF_GATE_SECS    = 5;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_PREP_DRAIN  = 4'd1,
    ST_PREP_FILL   = 4'd2,
    ST_ENTER_OUTER = 4'd3,
    ST_ENTER_INNER = 4'd4,
    ST_RAISE       = 4'd5,
    ST_LOWER       = 4'd6,
    ST_EXIT_INNER  = 4'd7,
    ST_EXIT_OUTER  = 4'd8
  } lock_state_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter for phase durations. A load always wins over a
// tick, so a tick landing on the entry edge of a phase is not counted.
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expire
);

  // Count register: load on phase entry, otherwise step down on each tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // The last second of a phase ends on the tick seen while the count is 1
  assign expire = tick && (count == W'(1));

endmodule

// File: rtl/lock_cycle_controller.sv
// Canal-lock sequencing FSM. Turns arrive/depart request edges into a
// full lockage: optional level preparation, entry gate, fill or drain,
// exit gate. Outer side is bay (low), inner side is lake (high).
module lock_cycle_controller
  import lock_pkg::*;
#(
  parameter int FILL_SECS  = DEF_FILL_SECS,
  parameter int DRAIN_SECS = DEF_DRAIN_SECS,
  parameter int GATE_SECS  = DEF_GATE_SECS,
  parameter int CNT_W      = LOCK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             arrive_signal,
  input  logic             depart_signal,
  output logic             outer_gate_open,
  output logic             inner_gate_open,
  output logic             pressure_up,
  output logic             pressure_down,
  output logic             chamber_high,
  output logic             busy,
  output logic [CNT_W-1:0] secs_left,
  output logic             done
);

  lock_state_t      state_q;
  lock_state_t      next_state;
  logic             arrive_prev;
  logic             depart_prev;
  logic             pending_arr;
  logic             pending_dep;
  logic             clr_arr;
  logic             clr_dep;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic [CNT_W-1:0] timer_count;
  logic             timer_expire;

  lock_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .tick     (tick_1hz),
    .count    (timer_count),
    .expire   (timer_expire)
  );

  assign secs_left = timer_count;

  // Next-state logic: IDLE dispatch (arrival first), then timed phase chain
  always_comb begin
    next_state = state_q;
    clr_arr    = 1'b0;
    clr_dep    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_arr) begin
          clr_arr    = 1'b1;
          next_state = chamber_high ? ST_PREP_DRAIN : ST_ENTER_OUTER;
        end else if (pending_dep) begin
          clr_dep    = 1'b1;
          next_state = chamber_high ? ST_ENTER_INNER : ST_PREP_FILL;
        end
      end
      ST_PREP_DRAIN:  if (timer_expire) next_state = ST_ENTER_OUTER;
      ST_ENTER_OUTER: if (timer_expire) next_state = ST_RAISE;
      ST_RAISE:       if (timer_expire) next_state = ST_EXIT_INNER;
      ST_EXIT_INNER:  if (timer_expire) next_state = ST_IDLE;
      ST_PREP_FILL:   if (timer_expire) next_state = ST_ENTER_INNER;
      ST_ENTER_INNER: if (timer_expire) next_state = ST_LOWER;
      ST_LOWER:       if (timer_expire) next_state = ST_EXIT_OUTER;
      ST_EXIT_OUTER:  if (timer_expire) next_state = ST_IDLE;
      default:        next_state = ST_IDLE;
    endcase
  end

  // Timer reload on every state change with the duration of the new state
  always_comb begin
    timer_load     = (next_state != state_q);
    timer_load_val = '0;
    case (next_state)
      ST_PREP_DRAIN, ST_LOWER:        timer_load_val = CNT_W'(DRAIN_SECS);
      ST_PREP_FILL, ST_RAISE:         timer_load_val = CNT_W'(FILL_SECS);
      ST_ENTER_OUTER, ST_ENTER_INNER,
      ST_EXIT_INNER, ST_EXIT_OUTER:   timer_load_val = CNT_W'(GATE_SECS);
      default:                        timer_load_val = '0;
    endcase
  end

  // State register plus registered one-hot command decode of the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      outer_gate_open <= 1'b0;
      inner_gate_open <= 1'b0;
      pressure_up     <= 1'b0;
      pressure_down   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= next_state;
      outer_gate_open <= (next_state == ST_ENTER_OUTER) || (next_state == ST_EXIT_OUTER);
      inner_gate_open <= (next_state == ST_ENTER_INNER) || (next_state == ST_EXIT_INNER);
      pressure_up     <= (next_state == ST_PREP_FILL)   || (next_state == ST_RAISE);
      pressure_down   <= (next_state == ST_PREP_DRAIN)  || (next_state == ST_LOWER);
      busy            <= (next_state != ST_IDLE);
      done            <= ((state_q == ST_EXIT_INNER) || (state_q == ST_EXIT_OUTER))
                         && (next_state == ST_IDLE);
    end
  end

  // Chamber level follows completion of each fill or drain phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chamber_high <= 1'b0;
    end else if (timer_expire) begin
      if ((state_q == ST_RAISE) || (state_q == ST_PREP_FILL)) begin
        chamber_high <= 1'b1;
      end else if ((state_q == ST_LOWER) || (state_q == ST_PREP_DRAIN)) begin
        chamber_high <= 1'b0;
      end
    end
  end

  // Edge detect and pending latches; a new edge outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arrive_prev <= 1'b0;
      depart_prev <= 1'b0;
      pending_arr <= 1'b0;
      pending_dep <= 1'b0;
    end else begin
      arrive_prev <= arrive_signal;
      depart_prev <= depart_signal;
      pending_arr <= (arrive_signal && !arrive_prev) || (pending_arr && !clr_arr);
      pending_dep <= (depart_signal && !depart_prev) || (pending_dep && !clr_dep);
    end
  end

endmodule
